// File: rtl/inst_fetch.sv
// Instruction fetch: byte-serial little-endian fetch from the memory controller, one-cycle push into the
// instruction queue, ROB/BP redirect. Define ICACHE_EN to add a direct-mapped one-word-per-line icache.
`timescale 1ns/1ps
module inst_fetch #(
    parameter logic [31:0] RESET_PC     = 32'h0,
    parameter int unsigned ICACHE_LINES = 64
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic        if_memctrl_en_out,
    output logic [31:0] if_memctrl_addr_out,
    input  logic        memctrl_if_valid_in,
    input  logic [7:0]  memctrl_if_data_in,
    input  logic        instqueue_if_full_in,
    output logic        if_instqueue_en_out,
    output logic [31:0] if_instqueue_inst_out,
    output logic [31:0] if_instqueue_pc_out,
    input  logic        rob_if_rst_in,
    input  logic [31:0] rob_if_pc_in,
    input  logic        bp_if_jump_in,
    input  logic [31:0] bp_if_pc_in
);
    localparam logic [1:0] FETCH    = 2'd0;
    localparam logic [1:0] PUSH     = 2'd1;
    localparam logic [1:0] REDIRECT = 2'd2;

    if ((ICACHE_LINES < 2) || ((ICACHE_LINES & (ICACHE_LINES - 1)) != 0)) begin : g_lines_check
        $error("ICACHE_LINES must be a power of two >= 2");
    end

    logic [1:0]  state;
    logic [31:0] pc;
    logic [1:0]  byte_cnt;
    logic [31:0] word_buf;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        hit;
    logic [31:0] hit_word;

    assign redirect    = rob_if_rst_in | bp_if_jump_in;
    assign redirect_pc = rob_if_rst_in ? rob_if_pc_in : bp_if_pc_in;

`ifdef ICACHE_EN
    localparam int unsigned IDX_W = $clog2(ICACHE_LINES);
    localparam int unsigned TAG_W = 30 - IDX_W;

    logic [31:0]             cache_data [ICACHE_LINES];
    logic [TAG_W-1:0]        cache_tag  [ICACHE_LINES];
    logic [ICACHE_LINES-1:0] cache_valid;
    logic [IDX_W-1:0]        idx;
    logic [TAG_W-1:0]        tag;
    logic                    fill;

    assign idx      = pc[2 +: IDX_W];
    assign tag      = pc[31 -: TAG_W];
    assign hit      = (state == FETCH) && (byte_cnt == 2'd0) && (pc[1:0] == 2'b00)
                      && cache_valid[idx] && (cache_tag[idx] == tag);
    assign hit_word = cache_data[idx];
    // Unaligned PCs are never filled, so they can never hit either.
    assign fill     = rdy_in && !redirect && (state == FETCH) && memctrl_if_valid_in
                      && (byte_cnt == 2'd3) && (pc[1:0] == 2'b00);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cache_valid <= '0;
        end else if (fill) begin
            cache_valid[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (fill) begin
            cache_data[idx] <= {memctrl_if_data_in, word_buf[23:0]};
            cache_tag[idx]  <= tag;
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_word = '0;
`endif

    assign if_memctrl_en_out   = !rst_in && (state == FETCH) && !hit;
    assign if_memctrl_addr_out = rst_in ? '0 : pc + {30'd0, byte_cnt};

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state                 <= FETCH;
            pc                    <= RESET_PC;
            byte_cnt              <= '0;
            word_buf              <= '0;
            if_instqueue_en_out   <= 1'b0;
            if_instqueue_inst_out <= '0;
            if_instqueue_pc_out   <= '0;
        end else if (rdy_in) begin
            if_instqueue_en_out <= 1'b0;
            if (redirect) begin
                pc       <= redirect_pc;
                byte_cnt <= '0;
                state    <= REDIRECT;
            end else begin
                case (state)
                    FETCH: begin
                        if (hit) begin
                            word_buf <= hit_word;
                            state    <= PUSH;
                        end else if (memctrl_if_valid_in) begin
                            word_buf[{byte_cnt, 3'b000} +: 8] <= memctrl_if_data_in;
                            byte_cnt                          <= byte_cnt + 2'd1;
                            if (byte_cnt == 2'd3) begin
                                state <= PUSH;
                            end
                        end
                    end
                    PUSH: begin
                        if (!instqueue_if_full_in) begin
                            if_instqueue_en_out   <= 1'b1;
                            if_instqueue_inst_out <= word_buf;
                            if_instqueue_pc_out   <= pc;
                            pc                    <= pc + 32'd4;
                            state                 <= FETCH;
                        end
                    end
                    default: state <= FETCH;
                endcase
            end
        end
    end
endmodule
